// File: rtl/filter_pkg.sv
// Shared types and constants for the 5x5 window / alpha-trimmed mean filter chain.
// Optional feature macro used by the window generator: WINDOW_EDGE_REPLICATE_EN.
package filter_pkg;

    localparam int WIN      = 5;
    localparam int WIN_TAPS = WIN * WIN;
    localparam int DW       = 8;

    typedef logic [DW-1:0] pixel_t;

    // Bit offset of tap (r,c), 1-based, inside the packed window; tap (1,1) sits at the MSB end.
    function automatic int tap_lsb(input int r, input int c, input int dw);
        return (WIN_TAPS - ((r - 1) * WIN + c)) * dw;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One video line of storage: combinational read, registered write at the same address,
// so a read in the write cycle returns the previous line's value.
module line_buffer #(
    parameter int DEPTH = 480,
    parameter int DW    = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_5x5_gen.sv
// 5x5 neighbourhood generator with border masking; 1-clock latency from din to window.
// Build option WINDOW_EDGE_REPLICATE_EN selects edge replication instead of zero padding.
module window_5x5_gen
    import filter_pkg::*;
#(
    parameter int H_DISP = 480,
    parameter int V_DISP = 272,
    parameter int DW     = filter_pkg::DW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din_vld,
    input  logic [DW-1:0]      din,
    input  logic               din_hsync,
    input  logic               din_vsync,
    output logic               out_vld,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic [25*DW-1:0]   window
);

    localparam int CW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int RW = (V_DISP > 1) ? $clog2(V_DISP) : 1;
    localparam int NLB = WIN - 1;

    logic [CW-1:0] col_cnt;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] row_cnt;
    logic [RW-1:0] cur_row;
    logic          vsync_d;
    logic          vs_rise;

    logic [DW-1:0] lb_rd [NLB];
    logic [DW-1:0] lb_wr [NLB];
    logic [DW-1:0] src   [WIN];
    logic [DW-1:0] taps  [WIN][WIN];
`ifdef WINDOW_EDGE_REPLICATE_EN
    logic [DW-1:0] fill;
`endif

    // A vsync rising edge retargets the current pixel to (0,0) before anything else sees it.
    always_comb begin
        vs_rise = din_vsync & ~vsync_d;
        cur_col = vs_rise ? '0 : col_cnt;
        cur_row = vs_rise ? '0 : row_cnt;
    end

    always_comb begin
        lb_wr[0] = din;
        for (int k = 1; k < NLB; k++) begin
            lb_wr[k] = lb_rd[k-1];
        end
    end

    for (genvar g = 0; g < NLB; g++) begin : g_lb
        line_buffer #(
            .DEPTH (H_DISP),
            .DW    (DW)
        ) u_lb (
            .clk     (clk),
            .we      (din_vld),
            .addr    (cur_col),
            .wr_data (lb_wr[g]),
            .rd_data (lb_rd[g])
        );
    end

    // Row r (0-based, row 4 = current line) reads LB(4-r) and is valid once row_cnt >= 4-r.
    always_comb begin
        src = '{default: '0};
        src[WIN-1] = din;
`ifdef WINDOW_EDGE_REPLICATE_EN
        fill = din;
        for (int r = WIN - 2; r >= 0; r--) begin
            if (int'(cur_row) >= (WIN - 1 - r)) begin
                src[r] = lb_rd[WIN-2-r];
                fill   = lb_rd[WIN-2-r];
            end else begin
                src[r] = fill;
            end
        end
`else
        for (int r = WIN - 2; r >= 0; r--) begin
            src[r] = (int'(cur_row) >= (WIN - 1 - r)) ? lb_rd[WIN-2-r] : '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (din_vld) begin
            if (cur_col == CW'(H_DISP - 1)) begin
                col_cnt <= '0;
                row_cnt <= (cur_row == RW'(V_DISP - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_cnt <= cur_col + 1'b1;
                row_cnt <= cur_row;
            end
        end else if (vs_rise) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d   <= 1'b0;
            out_vld   <= 1'b0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
        end else begin
            vsync_d   <= din_vsync;
            out_vld   <= din_vld;
            out_hsync <= din_hsync;
            out_vsync <= din_vsync;
        end
    end

    // At the first column the older taps are reloaded with the pad value rather than shifted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    taps[r][c] <= '0;
                end
            end
        end else if (din_vld) begin
            for (int r = 0; r < WIN; r++) begin
                taps[r][WIN-1] <= src[r];
                for (int c = 0; c < WIN - 1; c++) begin
`ifdef WINDOW_EDGE_REPLICATE_EN
                    taps[r][c] <= (cur_col == '0) ? src[r] : taps[r][c+1];
`else
                    taps[r][c] <= (cur_col == '0) ? '0 : taps[r][c+1];
`endif
                end
            end
        end
    end

    for (genvar r = 0; r < WIN; r++) begin : g_row
        for (genvar c = 0; c < WIN; c++) begin : g_col
            assign window[tap_lsb(r + 1, c + 1, DW) +: DW] = taps[r][c];
        end
    end

endmodule

// File: tb/tb_window_5x5_gen.sv
// Directed bench for window_5x5_gen at H_DISP=8, V_DISP=6; a position-tracking reference
// window backs the hand-computed corner and interior vectors.
module tb_window_5x5_gen;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int DW = 8;
    localparam int WB = 25 * DW;

    logic          clk;
    logic          rst_n;
    logic          din_vld;
    logic [DW-1:0] din;
    logic          din_hsync;
    logic          din_vsync;
    logic          out_vld;
    logic          out_hsync;
    logic          out_vsync;
    logic [WB-1:0] window;

    window_5x5_gen #(
        .H_DISP (H),
        .V_DISP (V),
        .DW     (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_vld   (din_vld),
        .din       (din),
        .din_hsync (din_hsync),
        .din_vsync (din_vsync),
        .out_vld   (out_vld),
        .out_hsync (out_hsync),
        .out_vsync (out_vsync),
        .window    (window)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] img [V][H];
    int            by = 0;
    int            bx = 0;
    logic          vs_prev = 1'b0;
    logic [WB-1:0] last_win = '0;
    logic [WB-1:0] exp_q [$];

    logic [WB-1:0] exp_57;
    logic [WB-1:0] exp_21;

    task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WB-1:0] model_win(input int y, input int x);
        logic [WB-1:0] w;
        w = '0;
        for (int r = 1; r <= 5; r++) begin
            for (int c = 1; c <= 5; c++) begin
                int yy;
                int xx;
                logic [DW-1:0] v;
                yy = y - (5 - r);
                xx = x - (5 - c);
`ifdef WINDOW_EDGE_REPLICATE_EN
                if (yy < 0) yy = 0;
                if (xx < 0) xx = 0;
`endif
                v = (yy < 0 || xx < 0) ? '0 : img[yy][xx];
                w[(25 - ((r - 1) * 5 + c)) * DW +: DW] = v;
            end
        end
        return w;
    endfunction

    function automatic logic [WB-1:0] corner_win(input logic [DW-1:0] v);
`ifdef WINDOW_EDGE_REPLICATE_EN
        return {25{v}};
`else
        return {192'b0, v};
`endif
    endfunction

    // driver: one clock of stimulus, then the 1-cycle-later outputs are scored
    task automatic send(input logic vld, input logic [DW-1:0] val, input logic hs,
                        input logic vs, input string tag);
        logic [WB-1:0] ew;
        if (vs && !vs_prev) begin
            by = 0;
            bx = 0;
        end
        vs_prev   = vs;
        din_vld   = vld;
        din       = val;
        din_hsync = hs;
        din_vsync = vs;
        if (vld) begin
            img[by][bx] = val;
            ew = model_win(by, bx);
            if (bx == H - 1) begin
                bx = 0;
                by = (by == V - 1) ? 0 : by + 1;
            end else begin
                bx = bx + 1;
            end
        end else begin
            ew = last_win;
        end
        last_win = ew;
        exp_q.push_back(ew);
        @(posedge clk);
        #1;
        check({tag, "_vld"},   WB'(out_vld),   WB'(vld));
        check({tag, "_hsync"}, WB'(out_hsync), WB'(hs));
        check({tag, "_vsync"}, WB'(out_vsync), WB'(vs));
        check({tag, "_win"},   window,         exp_q.pop_front());
    endtask

    task automatic pixel(input string tag);
        send(1'b1, DW'(by * 8 + bx), 1'b0, 1'b0, tag);
    endtask

    task automatic idle(input logic hs, input logic vs);
        send(1'b0, '0, hs, vs, "idle");
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_vld"},   WB'(out_vld),   '0);
        check({tag, "_hsync"}, WB'(out_hsync), '0);
        check({tag, "_vsync"}, WB'(out_vsync), '0);
        check({tag, "_win"},   window,         '0);
    endtask

    initial begin
        logic [11:0] pat_hs;
        logic [11:0] pat_vs;
        logic [11:0] pat_vld;
        int guard;

        exp_57 = {8'd11, 8'd12, 8'd13, 8'd14, 8'd15,
                  8'd19, 8'd20, 8'd21, 8'd22, 8'd23,
                  8'd27, 8'd28, 8'd29, 8'd30, 8'd31,
                  8'd35, 8'd36, 8'd37, 8'd38, 8'd39,
                  8'd43, 8'd44, 8'd45, 8'd46, 8'd47};
`ifdef WINDOW_EDGE_REPLICATE_EN
        exp_21 = {32'b0, 8'd1, 32'b0, 8'd1, 32'b0, 8'd1,
                  8'd8, 8'd8, 8'd8, 8'd8, 8'd9,
                  8'd16, 8'd16, 8'd16, 8'd16, 8'd17};
`else
        exp_21 = {40'b0, 40'b0, 32'b0, 8'd1,
                  24'b0, 8'd8, 8'd9, 24'b0, 8'd16, 8'd17};
`endif

        rst_n     = 1'b0;
        din_vld   = 1'b0;
        din       = '0;
        din_hsync = 1'b0;
        din_vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // frame 1: continuous pixels, hsync gaps between lines
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                pixel("f1");
                if (y == 2 && x == 1) check("px_2_1", window, exp_21);
                if (y == 5 && x == 7) check("px_5_7", window, exp_57);
            end
            idle(1'b1, 1'b0);
            idle(1'b0, 1'b0);
        end

        // 64 valid pixels separated by 3-cycle gaps; window must hold across gaps
        for (int i = 0; i < 64; i++) begin
            int py;
            int px;
            py = by;
            px = bx;
            pixel("gap");
            if (py == 5 && px == 7) check("gap_5_7", window, exp_57);
            repeat (3) idle(1'b0, 1'b0);
        end

        // mid-frame vsync coinciding with pixel (3,4)
        guard = 0;
        while (!(by == 3 && bx == 4) && guard < 100) begin
            pixel("pre_vs");
            guard++;
        end
        send(1'b1, 8'h5A, 1'b0, 1'b1, "resync");
        check("resync_corner", window, corner_win(8'h5A));
        for (int i = 0; i < 20; i++) pixel("post_vs");

        // asynchronous reset at (4,2)
        guard = 0;
        while (!(by == 4 && bx == 2) && guard < 100) begin
            pixel("pre_rst");
            guard++;
        end
        rst_n   = 1'b0;
        din_vld = 1'b0;
        din     = '0;
        #2;
        check_zero_outputs("async_rst");
        @(posedge clk);
        #1;
        check_zero_outputs("held_rst");
        rst_n    = 1'b1;
        by       = 0;
        bx       = 0;
        vs_prev  = 1'b0;
        last_win = '0;
        exp_q.delete();
        send(1'b1, 8'h5A, 1'b0, 1'b0, "restart");
        check("restart_corner", window, corner_win(8'h5A));
        for (int i = 0; i < 22; i++) pixel("restart");

        // sync pulse patterns, with and without din_vld
        pat_hs  = 12'b1011_0010_0110;
        pat_vs  = 12'b0111_0000_0110;
        pat_vld = 12'b1101_0101_1010;
        for (int i = 0; i < 12; i++) begin
            send(pat_vld[i], DW'(i * 3 + 1), pat_hs[i], pat_vs[i], "sync");
        end
        for (int i = 0; i < 10; i++) pixel("tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
